// File: rtl/argmax_stream_10_16_if.sv
// Handshake bundle for argmax_stream_10_16: signed element stream in, argmax result out.
// master is the environment side, slave is the argmax block side.
interface argmax_stream_10_16_if #(
  parameter int unsigned T  = 16,
  parameter int unsigned IW = 4
);
  logic [T-1:0]  s_data_in_x;
  logic          s_valid_x;
  logic          s_ready_x;
  logic [IW-1:0] m_data_out_y;
  logic [T-1:0]  m_max_y;
  logic          m_valid_y;
  logic          m_ready_y;

  modport master (
    output s_data_in_x,
    output s_valid_x,
    input  s_ready_x,
    input  m_data_out_y,
    input  m_max_y,
    input  m_valid_y,
    output m_ready_y
  );

  modport slave (
    input  s_data_in_x,
    input  s_valid_x,
    output s_ready_x,
    output m_data_out_y,
    output m_max_y,
    output m_valid_y,
    input  m_ready_y
  );
endinterface

// File: rtl/argmax_stream_10_16.sv
// Streaming argmax: consumes N signed elements per vector and emits the index and value of
// the largest one (earliest index wins ties) through a single registered output slot.
module argmax_stream_10_16 #(
  parameter int unsigned N  = 10,
  parameter int unsigned T  = 16,
  parameter int unsigned IW = $clog2(N)
) (
  input logic                  clk,
  input logic                  reset,
  argmax_stream_10_16_if.slave bus
);

  logic [IW-1:0]       cnt_q;
  logic [IW-1:0]       run_idx_q;
  logic signed [T-1:0] run_max_q;
  logic [IW-1:0]       out_idx_q;
  logic signed [T-1:0] out_max_q;
  logic                out_valid_q;

  logic signed [T-1:0] x;
  logic signed [T-1:0] win_max;
  logic [IW-1:0]       win_idx;
  logic                last;
  logic                s_ready;
  logic                in_xfer;
  logic                out_xfer;

  assign x        = bus.s_data_in_x;
  assign last     = (cnt_q == IW'(N - 1));
  assign out_xfer = out_valid_q && bus.m_ready_y;
  // Only the closing element needs the output slot, so only it can be stalled.
  assign s_ready  = !last || !out_valid_q || bus.m_ready_y;
  assign in_xfer  = bus.s_valid_x && s_ready;

  // Winner including the element currently on the input; strict > keeps the earliest index.
  always_comb begin
    win_max = run_max_q;
    win_idx = run_idx_q;
    if (cnt_q == '0) begin
      win_max = x;
      win_idx = '0;
    end else if (x > run_max_q) begin
      win_max = x;
      win_idx = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      run_idx_q   <= '0;
      run_max_q   <= '0;
      out_idx_q   <= '0;
      out_max_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (in_xfer) begin
        cnt_q     <= last ? '0 : cnt_q + 1'b1;
        run_max_q <= win_max;
        run_idx_q <= win_idx;
      end
      // A closing element reloads the slot even while it drains, giving back-to-back results.
      if (in_xfer && last) begin
        out_valid_q <= 1'b1;
        out_max_q   <= win_max;
        out_idx_q   <= win_idx;
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.s_ready_x    = s_ready;
  assign bus.m_data_out_y = out_idx_q;
  assign bus.m_max_y      = out_max_q;
  assign bus.m_valid_y    = out_valid_q;

endmodule

// File: tb/tb_argmax_stream_10_16.sv
// Self-checking bench for argmax_stream_10_16: directed scenarios plus a randomized
// handshake run checked against a plain software argmax.
module tb_argmax_stream_10_16;
  localparam int unsigned N  = 10;
  localparam int unsigned T  = 16;
  localparam int unsigned IW = 4;
  localparam int NV = 234;

  typedef logic [T-1:0] vec_t [N];

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int passed = 0;

  argmax_stream_10_16_if #(.T(T), .IW(IW)) bus ();

  argmax_stream_10_16 #(.N(N), .T(T), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_idx(input vec_t v);
    int best = 0;
    for (int i = 1; i < N; i++) if ($signed(v[i]) > $signed(v[best])) best = i;
    return best;
  endfunction

  function automatic logic [T-1:0] ref_max(input vec_t v);
    return v[ref_idx(v)];
  endfunction

  function automatic vec_t to_vec(input int a [N]);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = 16'(a[i]);
    return v;
  endfunction

  function automatic logic [T-1:0] rand_elem();
    logic [31:0] r = $urandom;
    int s;
    case ($urandom_range(0, 9))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2, 3, 4: return r[15:0];
      default: begin
        s = int'($urandom_range(0, 8)) - 4;
        return 16'(s);
      end
    endcase
  endfunction

  // Sets inputs just after a falling edge; callers observe the cycle before the next rising edge.
  task automatic drive(input logic rst, input logic v, input logic [T-1:0] d, input logic r);
    @(negedge clk);
    reset           = rst;
    bus.s_valid_x   = v;
    bus.s_data_in_x = d;
    bus.m_ready_y   = r;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 16'h1234, 1'b1);
    drive(1'b1, 1'b1, 16'h1234, 1'b1);
    checks++;
    if (bus.m_valid_y !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.m_valid_y);
    else passed++;
    checks++;
    if (bus.m_data_out_y !== 4'd0) $display("FAIL reset_idx: got %0d want 0", bus.m_data_out_y);
    else passed++;
    checks++;
    if (bus.m_max_y !== 16'h0000) $display("FAIL reset_max: got %0h want 0", bus.m_max_y);
    else passed++;
    checks++;
    if (bus.s_ready_x !== 1'b1) $display("FAIL reset_ready: got %0b want 1", bus.s_ready_x);
    else passed++;
  endtask

  task automatic test_basic();
    int a [N] = '{3, -1, 7, 2, 7, 0, -5, 1, 6, 4};
    vec_t v = to_vec(a);
    for (int k = 0; k < N; k++) begin
      drive(1'b0, 1'b1, v[k], 1'b1);
      checks++;
      if (bus.s_ready_x !== 1'b1 || bus.m_valid_y !== 1'b0)
        $display("FAIL basic_stream k=%0d: ready=%0b valid=%0b want 1/0", k, bus.s_ready_x,
                 bus.m_valid_y);
      else passed++;
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    checks++;
    if (bus.m_valid_y !== 1'b1) $display("FAIL basic_valid: got %0b want 1", bus.m_valid_y);
    else passed++;
    checks++;
    if (bus.m_data_out_y !== IW'(ref_idx(v)) || bus.m_data_out_y !== 4'd2)
      $display("FAIL basic_idx: got %0d want 2", bus.m_data_out_y);
    else passed++;
    checks++;
    if (bus.m_max_y !== 16'd7) $display("FAIL basic_max: got %0h want 7", bus.m_max_y);
    else passed++;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (bus.m_valid_y !== 1'b0) $display("FAIL basic_drain: got %0b want 0", bus.m_valid_y);
    else passed++;
  endtask

  task automatic test_extremes();
    int an [N] = '{-9, -3, -3, -8, -32768, -100, -4, -7, -5, -6};
    int ap [N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32767};
    vec_t vs [2];
    vs[0] = to_vec(an);
    vs[1] = to_vec(ap);
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < N; k++) drive(1'b0, 1'b1, vs[j][k], 1'b1);
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      checks++;
      if (bus.m_valid_y !== 1'b1 || bus.m_data_out_y !== IW'(ref_idx(vs[j])) ||
          bus.m_max_y !== ref_max(vs[j]))
        $display("FAIL extreme_vec%0d: got v=%0b idx=%0d max=%0h want 1/%0d/%0h", j,
                 bus.m_valid_y, bus.m_data_out_y, bus.m_max_y, ref_idx(vs[j]), ref_max(vs[j]));
      else passed++;
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_backpressure();
    vec_t va, vb;
    for (int k = 0; k < N; k++) begin
      va[k] = rand_elem();
      vb[k] = rand_elem();
    end
    for (int k = 0; k < N; k++) drive(1'b0, 1'b1, va[k], 1'b0);
    for (int k = 0; k < N - 1; k++) begin
      drive(1'b0, 1'b1, vb[k], 1'b0);
      checks++;
      if (bus.s_ready_x !== 1'b1 || bus.m_valid_y !== 1'b1 ||
          bus.m_data_out_y !== IW'(ref_idx(va)) || bus.m_max_y !== ref_max(va))
        $display("FAIL bp_hold k=%0d: rdy=%0b v=%0b idx=%0d max=%0h want 1/1/%0d/%0h", k,
                 bus.s_ready_x, bus.m_valid_y, bus.m_data_out_y, bus.m_max_y, ref_idx(va),
                 ref_max(va));
      else passed++;
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, vb[N-1], 1'b0);
      checks++;
      if (bus.s_ready_x !== 1'b0 || bus.m_data_out_y !== IW'(ref_idx(va)) ||
          bus.m_max_y !== ref_max(va))
        $display("FAIL bp_stall c=%0d: rdy=%0b idx=%0d max=%0h want 0/%0d/%0h", c,
                 bus.s_ready_x, bus.m_data_out_y, bus.m_max_y, ref_idx(va), ref_max(va));
      else passed++;
    end
    drive(1'b0, 1'b1, vb[N-1], 1'b1);
    checks++;
    if (bus.s_ready_x !== 1'b1 || bus.m_valid_y !== 1'b1 || bus.m_data_out_y !== IW'(ref_idx(va)))
      $display("FAIL bp_release: rdy=%0b v=%0b idx=%0d want 1/1/%0d", bus.s_ready_x,
               bus.m_valid_y, bus.m_data_out_y, ref_idx(va));
    else passed++;
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0, 16'h0, c[0]);
      checks++;
      if (bus.m_valid_y !== 1'b1 || bus.m_data_out_y !== IW'(ref_idx(vb)) ||
          bus.m_max_y !== ref_max(vb))
        $display("FAIL bp_second c=%0d: v=%0b idx=%0d max=%0h want 1/%0d/%0h", c,
                 bus.m_valid_y, bus.m_data_out_y, bus.m_max_y, ref_idx(vb), ref_max(vb));
      else passed++;
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (bus.m_valid_y !== 1'b0) $display("FAIL bp_dup: valid=%0b want 0", bus.m_valid_y);
    else passed++;
  endtask

  task automatic test_back_to_back();
    vec_t vs [3];
    int vi;
    for (int j = 0; j < 3; j++) for (int k = 0; k < N; k++) vs[j][k] = rand_elem();
    for (int i = 0; i <= 3 * N; i++) begin
      if (i < 3 * N) drive(1'b0, 1'b1, vs[i / N][i % N], 1'b1);
      else drive(1'b0, 1'b0, 16'h0, 1'b1);
      if (i < 3 * N) begin
        checks++;
        if (bus.s_ready_x !== 1'b1) $display("FAIL b2b_ready i=%0d: got 0 want 1", i);
        else passed++;
      end
      checks++;
      if (bus.m_valid_y !== ((i % N == 0) && i > 0))
        $display("FAIL b2b_valid i=%0d: got %0b", i, bus.m_valid_y);
      else passed++;
      if (i % N == 0 && i > 0) begin
        vi = i / N - 1;
        checks++;
        if (bus.m_data_out_y !== IW'(ref_idx(vs[vi])) || bus.m_max_y !== ref_max(vs[vi]))
          $display("FAIL b2b_result i=%0d: idx=%0d max=%0h want %0d/%0h", i,
                   bus.m_data_out_y, bus.m_max_y, ref_idx(vs[vi]), ref_max(vs[vi]));
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int a [N] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    vec_t v = to_vec(a);
    for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, 16'h7FF0, 1'b1);
    drive(1'b1, 1'b1, 16'h7FFF, 1'b1);
    for (int k = 0; k < N; k++) begin
      drive(1'b0, 1'b1, v[k], 1'b1);
      checks++;
      if (bus.m_valid_y !== 1'b0) $display("FAIL rmid_aborted k=%0d: valid=1 want 0", k);
      else passed++;
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    checks++;
    if (bus.m_valid_y !== 1'b1 || bus.m_data_out_y !== 4'd9 || bus.m_max_y !== 16'd10)
      $display("FAIL rmid_result: v=%0b idx=%0d max=%0h want 1/9/a", bus.m_valid_y,
               bus.m_data_out_y, bus.m_max_y);
    else passed++;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (bus.m_valid_y !== 1'b0) $display("FAIL rmid_single: valid=1 want 0");
    else passed++;
  endtask

  task automatic test_random();
    vec_t vs [NV];
    int k = 0, vi = 0, got = 0, cyc = 0;
    logic ev = 1'b0, v, r, er, close;
    for (int j = 0; j < NV; j++) for (int e = 0; e < N; e++) vs[j][e] = rand_elem();
    while (got < NV && cyc < 40000) begin
      v = (vi < NV) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 1) == 1);
      drive(1'b0, v, v ? vs[vi][k] : rand_elem(), r);
      cyc++;
      er = (k != N - 1) || !ev || r;
      checks++;
      if (bus.s_ready_x !== er || bus.m_valid_y !== ev)
        $display("FAIL rand_hs cyc=%0d: rdy=%0b v=%0b want %0b/%0b", cyc, bus.s_ready_x,
                 bus.m_valid_y, er, ev);
      else passed++;
      if (ev && r) begin
        checks++;
        if (bus.m_data_out_y !== IW'(ref_idx(vs[got])) || bus.m_max_y !== ref_max(vs[got]))
          $display("FAIL rand_result n=%0d: idx=%0d max=%0h want %0d/%0h", got,
                   bus.m_data_out_y, bus.m_max_y, ref_idx(vs[got]), ref_max(vs[got]));
        else passed++;
        got++;
      end
      close = v && er && (k == N - 1);
      if (v && er) begin
        if (k == N - 1) begin
          k = 0;
          vi++;
        end else k++;
      end
      if (close) ev = 1'b1;
      else if (ev && r) ev = 1'b0;
    end
    checks++;
    if (got != NV) $display("FAIL rand_count: got %0d results want %0d", got, NV);
    else passed++;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (bus.m_valid_y !== 1'b0) $display("FAIL rand_extra: valid=1 after last result");
    else passed++;
  endtask

  initial begin
    bus.s_valid_x   = 1'b0;
    bus.s_data_in_x = '0;
    bus.m_ready_y   = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
